ysyx_24070016_wbu: RTL



---
 rtl/ysyx_24070016_wbu.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ysyx_24070016_wbu.sv
// rtl/ysyx_24070016_wbu.sv - write-back stage with EXU/LSU arbitration and busy scoreboard (optional YSYX_24070016_WB_BYPASS_EN)
module ysyx_24070016_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  fwd1_valid,
    output logic                  fwd2_valid,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [DATA_WIDTH-1:0] fwd2_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [1:0]            exu_wait_q, exu_wait_d;
    logic                  stg_v_q, stg_v_d;
    logic [ADDR_WIDTH-1:0] stg_rd_q, stg_rd_d;
    logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  exu_grant, lsu_grant;
    logic                  iss_fire;

    // LSU has priority; EXU takes the slot after three consecutive losses
    always_comb begin
        exu_grant  = exu_valid && (!lsu_valid || exu_wait_q == 2'd3);
        lsu_grant  = lsu_valid && !exu_grant;
        exu_wait_d = (exu_valid && !exu_grant) ? exu_wait_q + 2'd1 : 2'd0;
    end

    assign exu_ready = exu_grant;
    assign lsu_ready = lsu_grant;

    // Stage loads the winner; rd/data are held when idle since v gates the write
    always_comb begin
        stg_v_d    = exu_grant || lsu_grant;
        stg_rd_d   = stg_rd_q;
        stg_data_d = stg_data_q;
        if (exu_grant) begin
            stg_rd_d   = exu_rd;
            stg_data_d = exu_data;
        end else if (lsu_grant) begin
            stg_rd_d   = lsu_rd;
            stg_data_d = lsu_data;
        end
    end

    assign rf_wen   = stg_v_q && (stg_rd_q != '0);
    assign rf_waddr = stg_rd_q;
    assign rf_wdata = stg_data_q;

    // A busy register may be re-issued in the same cycle its writer retires
    always_comb begin
        iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || (rf_wen && (rf_waddr == iss_rd));
        iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
    end

    // Retire clears first so a same-cycle re-issue leaves the bit set
    always_comb begin
        busy_d = busy_q;
        if (rf_wen) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Source hazards, optionally resolved by forwarding the stage value
    always_comb begin
`ifdef YSYX_24070016_WB_BYPASS_EN
        fwd1_valid = (rs1 != '0) && rf_wen && (rf_waddr == rs1);
        fwd2_valid = (rs2 != '0) && rf_wen && (rf_waddr == rs2);
        fwd1_data  = rf_wdata;
        fwd2_data  = rf_wdata;
`else
        fwd1_valid = 1'b0;
        fwd2_valid = 1'b0;
        fwd1_data  = '0;
        fwd2_data  = '0;
`endif
        hazard1 = (rs1 != '0) && busy_q[rs1] && !fwd1_valid;
        hazard2 = (rs2 != '0) && busy_q[rs2] && !fwd2_valid;
    end

    // State registers; reset drops any staged result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu_wait_q <= 2'd0;
            stg_v_q    <= 1'b0;
            stg_rd_q   <= '0;
            stg_data_q <= '0;
            busy_q     <= '0;
        end else begin
            exu_wait_q <= exu_wait_d;
            stg_v_q    <= stg_v_d;
            stg_rd_q   <= stg_rd_d;
            stg_data_q <= stg_data_d;
            busy_q     <= busy_d;
        end
    end

endmodule
